fetch_unit: RTL and testbench

Instruction-fetch stage of the pipelined core: owns the PC, issues requests to instruction memory over a request/response handshake, and fills the IF/ID pipeline register. It obeys the `pc_en` and `if_id_en` stall controls from the load-use hazard logic. It also obeys the taken-branch/jump redirect from EX. A one-entry skid buffer keeps any fetched instruction that arrives during a stall.

---
 rtl/fetch_unit.sv | 163 ++++++++++++++++
 tb/tb_fetch_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage. Owns the PC, issues one instruction-memory request
// at a time over a req/ready + rvalid handshake, and fills the IF/ID pipeline
// register. A one-entry skid buffer keeps a response that arrives while IF/ID
// is stalled. A taken branch/jump redirect from EX has top priority: it
// reloads the PC, flushes IF/ID to a bubble and discards any stale response.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   pc_en                0 = hold PC, issue no new request
//   if_id_en             0 = hold IF/ID contents
//   redirect, redirect_pc  EX redirect and its target (bits [1:0] ignored)
//   imem_req, imem_addr  request valid / address (current PC)
//   imem_ready           memory accepts request when imem_req && imem_ready
//   imem_rvalid, imem_rdata  response valid / instruction word
//   if_id_pc, if_id_instr, if_id_valid  IF/ID register contents
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_en,
    input  logic        if_id_en,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid
);

    localparam logic [1:0] ST_FETCH   = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;
    localparam logic [1:0] ST_DISCARD = 2'd3;

    logic [1:0]  state_reg,       state_next;
    logic [31:0] pc_reg,          pc_next;
    logic [31:0] req_pc_reg,      req_pc_next;
    logic [31:0] skid_pc_reg,     skid_pc_next;
    logic [31:0] skid_instr_reg,  skid_instr_next;
    logic [31:0] if_id_pc_reg,    if_id_pc_next;
    logic [31:0] if_id_instr_reg, if_id_instr_next;
    logic        if_id_valid_reg, if_id_valid_next;

    logic accept;

    // Request is gated by redirect so a stale PC is never handed to memory.
    // It depends only on state, PC and the stall/redirect controls, never on
    // the response side, so no combinational path runs from rvalid to req.
    assign imem_req  = !rst && (state_reg == ST_FETCH) && pc_en && !redirect;
    assign imem_addr = pc_reg;
    assign accept    = imem_req && imem_ready;

    assign if_id_pc    = if_id_pc_reg;
    assign if_id_instr = if_id_instr_reg;
    assign if_id_valid = if_id_valid_reg;

    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        req_pc_next      = req_pc_reg;
        skid_pc_next     = skid_pc_reg;
        skid_instr_next  = skid_instr_reg;
        if_id_pc_next    = if_id_pc_reg;
        if_id_instr_next = if_id_instr_reg;
        if_id_valid_next = if_id_valid_reg;

        // Bubble by default whenever IF/ID advances; a load below overrides.
        // The PC field is left alone so it still names the last real slot.
        if (if_id_en) begin
            if_id_valid_next = 1'b0;
            if_id_instr_next = NOP;
        end

        case (state_reg)
            ST_FETCH: begin
                // A response here would be a protocol violation; ignore it.
                if (accept) begin
                    req_pc_next = pc_reg;
                    pc_next     = pc_reg + 32'd4;
                    state_next  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    if (if_id_en) begin
                        if_id_pc_next    = req_pc_reg;
                        if_id_instr_next = imem_rdata;
                        if_id_valid_next = 1'b1;
                        state_next       = ST_FETCH;
                    end else begin
                        skid_pc_next    = req_pc_reg;
                        skid_instr_next = imem_rdata;
                        state_next      = ST_FULL;
                    end
                end
            end
            ST_FULL: begin
                if (if_id_en) begin
                    if_id_pc_next    = skid_pc_reg;
                    if_id_instr_next = skid_instr_reg;
                    if_id_valid_next = 1'b1;
                    state_next       = ST_FETCH;
                end
            end
            ST_DISCARD: begin
                // Swallow the response of a request made before a redirect.
                if (imem_rvalid) begin
                    state_next = ST_FETCH;
                end
            end
            default: begin
                state_next = ST_FETCH;
            end
        endcase

        // Redirect overrides both stalls. The skid buffer is only meaningful
        // in FULL, so leaving FULL empties it. A request still in flight
        // (WAIT without response yet) must have its response discarded.
        if (redirect) begin
            pc_next          = {redirect_pc[31:2], 2'b00};
            if_id_valid_next = 1'b0;
            if_id_instr_next = NOP;
            if (((state_reg == ST_WAIT) || (state_reg == ST_DISCARD)) && !imem_rvalid) begin
                state_next = ST_DISCARD;
            end else begin
                state_next = ST_FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_FETCH;
            pc_reg          <= RESET_PC;
            req_pc_reg      <= 32'd0;
            skid_pc_reg     <= 32'd0;
            skid_instr_reg  <= NOP;
            if_id_pc_reg    <= 32'd0;
            if_id_instr_reg <= NOP;
            if_id_valid_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            req_pc_reg      <= req_pc_next;
            skid_pc_reg     <= skid_pc_next;
            skid_instr_reg  <= skid_instr_next;
            if_id_pc_reg    <= if_id_pc_next;
            if_id_instr_reg <= if_id_instr_next;
            if_id_valid_reg <= if_id_valid_next;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit (RESET_PC = 0x100). A table of per-cycle
// vectors drives inputs after the falling edge and checks imem_req/imem_addr
// and the IF/ID outputs shortly after, before the next rising edge; the
// IF/ID expectation in each row is the result of the earlier rows. Memory
// data is hand-computed as 0xA0 + address. Hand-written sequences follow
// for a 3-cycle memory latency and the 1-cycle throughput cadence.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        pc_en;
    logic        if_id_en;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_unit #(
        .RESET_PC (32'h0000_0100),
        .NOP      (NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_en       (pc_en),
        .if_id_en    (if_id_en),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_id_pc    (if_id_pc),
        .if_id_instr (if_id_instr),
        .if_id_valid (if_id_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        pc_en;
        logic        if_id_en;
        logic        redirect;
        logic [31:0] redirect_pc;
        logic        ready;
        logic        rvalid;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_valid;
    } vec_t;

    vec_t vecs[$];

    task automatic v(input logic r, input logic pe, input logic ie, input logic rd,
                     input logic [31:0] rdpc, input logic rdy, input logic rv,
                     input logic [31:0] rdat, input logic ereq, input logic [31:0] eaddr,
                     input logic [31:0] epc, input logic [31:0] einstr, input logic eval);
        vec_t t;
        t.rst = r; t.pc_en = pe; t.if_id_en = ie; t.redirect = rd;
        t.redirect_pc = rdpc; t.ready = rdy; t.rvalid = rv; t.rdata = rdat;
        t.e_req = ereq; t.e_addr = eaddr; t.e_pc = epc; t.e_instr = einstr;
        t.e_valid = eval;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %08h expected %08h", name, act, exp);
        end else begin
            $display("[TB] ok %s: %08h", name, act);
        end
    endtask

    int          found_at;
    int          valid_cnt;
    logic        acc_prev;
    logic [31:0] acc_addr;

    initial begin
        // rst pe ie rd rdpc        rdy rv rdata     | req addr         if_pc        if_instr  val
        v(1, 1, 1, 0, 32'h0,       1, 0, 32'h0,      0, 32'h100,      32'h0,       NOP,      0); // 0 reset state
        v(0, 1, 1, 0, 32'h0,       1, 0, 32'h0,      1, 32'h100,      32'h0,       NOP,      0); // 1 first req
        v(0, 1, 1, 0, 32'h0,       1, 1, 32'h1A0,    0, 32'h104,      32'h0,       NOP,      0); // 2 resp
        v(0, 1, 1, 0, 32'h0,       1, 0, 32'h0,      1, 32'h104,      32'h100,     32'h1A0,  1); // 3
        v(0, 1, 1, 0, 32'h0,       1, 1, 32'h1A4,    0, 32'h108,      32'h100,     NOP,      0); // 4 bubble
        v(0, 1, 1, 0, 32'h0,       1, 0, 32'h0,      1, 32'h108,      32'h104,     32'h1A4,  1); // 5
        v(0, 1, 0, 0, 32'h0,       1, 1, 32'h1A8,    0, 32'h10C,      32'h104,     NOP,      0); // 6 resp into skid
        v(0, 1, 0, 0, 32'h0,       1, 0, 32'h0,      0, 32'h10C,      32'h104,     NOP,      0); // 7 FULL
        v(0, 1, 0, 0, 32'h0,       1, 0, 32'h0,      0, 32'h10C,      32'h104,     NOP,      0); // 8 FULL
        v(0, 1, 1, 0, 32'h0,       1, 0, 32'h0,      0, 32'h10C,      32'h104,     NOP,      0); // 9 release
        v(0, 1, 0, 0, 32'h0,       1, 0, 32'h0,      1, 32'h10C,      32'h108,     32'h1A8,  1); // 10 skid in IF/ID
        v(0, 1, 0, 1, 32'h203,     1, 0, 32'h0,      0, 32'h110,      32'h108,     32'h1A8,  1); // 11 redirect in WAIT
        v(0, 1, 1, 0, 32'h0,       1, 0, 32'h0,      0, 32'h200,      32'h108,     NOP,      0); // 12 flushed
        v(0, 1, 1, 0, 32'h0,       1, 1, 32'hDEAD,   0, 32'h200,      32'h108,     NOP,      0); // 13 stale resp
        v(0, 1, 1, 0, 32'h0,       1, 0, 32'h0,      1, 32'h200,      32'h108,     NOP,      0); // 14 req target
        v(0, 1, 1, 0, 32'h0,       1, 1, 32'h2A0,    0, 32'h204,      32'h108,     NOP,      0); // 15
        v(0, 1, 0, 0, 32'h0,       1, 0, 32'h0,      1, 32'h204,      32'h200,     32'h2A0,  1); // 16
        v(0, 1, 0, 1, 32'h300,     1, 1, 32'h2A4,    0, 32'h208,      32'h200,     32'h2A0,  1); // 17 redirect+rvalid
        v(0, 1, 0, 0, 32'h0,       0, 0, 32'h0,      1, 32'h300,      32'h200,     NOP,      0); // 18 no skid, req
        v(0, 0, 1, 0, 32'h0,       0, 0, 32'h0,      0, 32'h300,      32'h200,     NOP,      0); // 19 pc_en=0
        v(0, 1, 1, 0, 32'h0,       0, 0, 32'h0,      1, 32'h300,      32'h200,     NOP,      0); // 20
        v(0, 0, 1, 0, 32'h0,       1, 0, 32'h0,      0, 32'h300,      32'h200,     NOP,      0); // 21 ready but no req
        v(0, 1, 1, 0, 32'h0,       1, 0, 32'h0,      1, 32'h300,      32'h200,     NOP,      0); // 22 accept
        v(0, 0, 1, 0, 32'h0,       1, 1, 32'h3A0,    0, 32'h304,      32'h200,     NOP,      0); // 23 resp, pc_en=0
        v(0, 0, 1, 0, 32'h0,       1, 0, 32'h0,      0, 32'h304,      32'h300,     32'h3A0,  1); // 24
        v(0, 1, 1, 1, 32'hFFFFFFFF,1, 0, 32'h0,      0, 32'h304,      32'h300,     NOP,      0); // 25 redirect in FETCH
        v(0, 1, 1, 0, 32'h0,       1, 0, 32'h0,      1, 32'hFFFFFFFC, 32'h300,     NOP,      0); // 26 top address
        v(0, 1, 1, 0, 32'h0,       1, 1, 32'h9C,     0, 32'h0,        32'h300,     NOP,      0); // 27 wrapped pc
        v(0, 1, 0, 0, 32'h0,       1, 0, 32'h0,      1, 32'h0,        32'hFFFFFFFC,32'h9C,   1); // 28
        v(1, 1, 1, 0, 32'h0,       1, 0, 32'h0,      0, 32'h4,        32'hFFFFFFFC,32'h9C,   1); // 29 reset in WAIT
        v(0, 1, 1, 0, 32'h0,       0, 0, 32'h0,      1, 32'h100,      32'h0,       NOP,      0); // 30 back to reset
        v(0, 1, 1, 0, 32'h0,       0, 1, 32'h5555,   1, 32'h100,      32'h0,       NOP,      0); // 31 rvalid in FETCH
        v(0, 1, 1, 0, 32'h0,       0, 0, 32'h0,      1, 32'h100,      32'h0,       NOP,      0); // 32 ignored

        rst = 1'b1; pc_en = 1'b0; if_id_en = 1'b0; redirect = 1'b0;
        redirect_pc = 32'h0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst         = vecs[i].rst;
            pc_en       = vecs[i].pc_en;
            if_id_en    = vecs[i].if_id_en;
            redirect    = vecs[i].redirect;
            redirect_pc = vecs[i].redirect_pc;
            imem_ready  = vecs[i].ready;
            imem_rvalid = vecs[i].rvalid;
            imem_rdata  = vecs[i].rdata;
            #2;
            n_tests++;
            if (imem_req !== vecs[i].e_req || imem_addr !== vecs[i].e_addr ||
                if_id_pc !== vecs[i].e_pc || if_id_instr !== vecs[i].e_instr ||
                if_id_valid !== vecs[i].e_valid) begin
                n_fail++;
                $display("[TB] FAIL row%0d: got req=%0b addr=%08h pc=%08h instr=%08h v=%0b expected req=%0b addr=%08h pc=%08h instr=%08h v=%0b",
                         i, imem_req, imem_addr, if_id_pc, if_id_instr, if_id_valid,
                         vecs[i].e_req, vecs[i].e_addr, vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_valid);
            end else begin
                $display("[TB] row%0d ok: req=%0b addr=%08h pc=%08h instr=%08h v=%0b",
                         i, imem_req, imem_addr, if_id_pc, if_id_instr, if_id_valid);
            end
        end

        // 3-cycle latency: accept at N, rvalid at N+3, IF/ID valid at N+4.
        @(negedge clk);
        rst = 1'b0; pc_en = 1'b1; if_id_en = 1'b1; redirect = 1'b1;
        redirect_pc = 32'h400; imem_ready = 1'b1; imem_rvalid = 1'b0;
        @(negedge clk);
        redirect = 1'b0;
        #2;
        check("lat_req", {31'd0, imem_req}, 32'd1);
        check("lat_addr", imem_addr, 32'h400);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #2;
            check("lat_wait_noreq", {31'd0, imem_req}, 32'd0);
        end
        @(negedge clk);
        imem_rvalid = 1'b1; imem_rdata = 32'h4A0;
        found_at = -1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            imem_rvalid = 1'b0; pc_en = 1'b0;
            #2;
            if (if_id_valid === 1'b1) begin
                found_at = i;
                break;
            end
        end
        check("lat_cycles", found_at, 32'd0);
        check("lat_pc", if_id_pc, 32'h400);
        check("lat_instr", if_id_instr, 32'h4A0);

        // 1-cycle memory with ready=1: one instruction per 2 cycles.
        acc_prev = 1'b0; acc_addr = 32'h0; valid_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            pc_en = 1'b1;
            imem_rvalid = acc_prev;
            imem_rdata  = acc_addr + 32'hA0;
            #2;
            if (if_id_valid === 1'b1) valid_cnt++;
            acc_prev = imem_req;
            acc_addr = imem_addr;
        end
        check("tput_count", valid_cnt, 32'd9);
        @(negedge clk);
        imem_rvalid = 1'b0; pc_en = 1'b0;
        #2;
        check("tput_last_pc", if_id_pc, 32'h428);
        check("tput_last_instr", if_id_instr, 32'h4C8);
        check("tput_last_valid", {31'd0, if_id_valid}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
